// File: rtl/serial_reg_pkg.sv
// Shared definitions for the UART command/register bridge: FSM states,
// command byte layout and the default address map.
package serial_reg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrCommit,
    StRdSnap,
    StRdSend,
    StFifoReq,
    StFifoCap
  } state_e;

  // Command byte: [7] valid, [6] write/not-read, [5:0] address.
  localparam int unsigned CMD_VALID_BIT = 7;
  localparam int unsigned CMD_WRITE_BIT = 6;
  localparam int unsigned ADDR_MSB      = 5;
  localparam int unsigned ADDR_LSB      = 0;

  // Default address map.
  localparam int unsigned DEF_NUM_REGS    = 8;
  localparam int unsigned DEF_NUM_STATUS  = 4;
  localparam int unsigned DEF_STATUS_BASE = 16;
  localparam int unsigned DEF_FIFO_ADDR   = 32;

endpackage

// File: rtl/serial_tx_sequencer.sv
// Byte-serial transmit sequencer: owns the tx_start/guard/tx_busy handshake.
// Either shifts out a loaded word LSB first, or sends one pushed byte.
module serial_tx_sequencer #(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [REG_WIDTH-1:0] load_word,
  input  logic                 push,
  input  logic [7:0]           push_byte,
  input  logic                 tx_busy,
  output logic                 ready,
  output logic                 pending,
  output logic [7:0]           tx_data,
  output logic                 tx_start
);

  localparam int unsigned REG_BYTES = REG_WIDTH / 8;
  localparam int unsigned CntW      = $clog2(REG_BYTES + 1);

  logic [REG_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]      left_q, left_d;
  logic [7:0]           data_q, data_d;
  logic                 start_q, start_d;
  logic                 guard_q;

  // tx_busy is not trusted during the start pulse nor the cycle after it.
  assign ready    = !tx_busy && !start_q && !guard_q;
  assign pending  = (left_q != '0);
  assign tx_data  = data_q;
  assign tx_start = start_q;

  // Next-state: load a word, send a pushed byte, or send the next shifted byte.
  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    data_d  = data_q;
    start_d = 1'b0;
    if (load) begin
      shift_d = load_word;
      left_d  = CntW'(REG_BYTES);
    end else if (push) begin
      data_d  = push_byte;
      start_d = 1'b1;
    end else if (pending && ready) begin
      data_d  = shift_q[7:0];
      start_d = 1'b1;
      shift_d = shift_q >> 8;
      left_d  = left_q - CntW'(1);
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      left_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
      data_q  <= data_d;
      start_q <= start_d;
      guard_q <= start_q;
    end
  end

endmodule

// File: rtl/serial_reg_bridge.sv
// UART byte stream to register-bank bridge: multi-byte writes, atomic status
// snapshots and bounded FIFO burst drains. Optional inter-byte timeout is
// enabled by defining SERIAL_REG_BRIDGE_TIMEOUT_EN.
module serial_reg_bridge
  import serial_reg_pkg::*;
#(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
  parameter int unsigned NUM_STATUS     = DEF_NUM_STATUS,
  parameter int unsigned STATUS_BASE    = DEF_STATUS_BASE,
  parameter int unsigned FIFO_ADDR      = DEF_FIFO_ADDR,
  parameter int unsigned BURST_MAX      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [7:0]                      tx_data,
  output logic                            tx_start,
  input  logic                            tx_busy,
  output logic [NUM_REGS*REG_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]             reg_wr_strobe,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_in,
  input  logic                            fifo_empty,
  input  logic [7:0]                      fifo_data,
  output logic                            fifo_rd_en,
  output logic                            err_flag
);

  localparam int unsigned REG_BYTES = REG_WIDTH / 8;
  localparam int unsigned BcntW     = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;
  localparam int unsigned BurstW    = $clog2(BURST_MAX + 1);
  localparam int unsigned AddrW     = ADDR_MSB - ADDR_LSB + 1;

  state_e                        state_q, state_d;
  logic [AddrW-1:0]              addr_q, addr_d;
  logic [REG_WIDTH-1:0]          wbuf_q, wbuf_d;
  logic [BcntW-1:0]              bcnt_q, bcnt_d;
  logic [BurstW-1:0]             burst_q, burst_d;
  logic                          err_q, err_d;
  logic [NUM_REGS*REG_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]           strobe_q, strobe_d;

  logic                 seq_load, seq_push, seq_ready, seq_pending;
  logic [REG_WIDTH-1:0] rd_word;
  logic                 rd_hit;
  logic                 cmd_seen;
  logic                 timeout;

  assign cmd_seen      = rx_valid && rx_data[CMD_VALID_BIT];
  assign reg_q         = regs_q;
  assign reg_wr_strobe = strobe_q;
  assign err_flag      = err_q;

  serial_tx_sequencer #(
    .REG_WIDTH (REG_WIDTH)
  ) u_tx_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (seq_load),
    .load_word (rd_word),
    .push      (seq_push),
    .push_byte (fifo_data),
    .tx_busy   (tx_busy),
    .ready     (seq_ready),
    .pending   (seq_pending),
    .tx_data   (tx_data),
    .tx_start  (tx_start)
  );

  // Read-address decode: pick the RW register or status word to snapshot.
  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (int'(addr_q) == i) begin
        rd_word = regs_q[i*REG_WIDTH +: REG_WIDTH];
        rd_hit  = 1'b1;
      end
    end
    for (int j = 0; j < int'(NUM_STATUS); j++) begin
      if (int'(addr_q) == int'(STATUS_BASE) + j) begin
        rd_word = status_in[j*REG_WIDTH +: REG_WIDTH];
        rd_hit  = 1'b1;
      end
    end
  end

`ifdef SERIAL_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_q, to_d;
  logic           to_run;

  // Count down only while waiting on the host or on a stuck transmitter.
  always_comb begin
    to_run = (state_q == StWrData) || ((state_q == StFifoReq) && tx_busy);
    to_d   = to_q;
    if (rx_valid || !to_run) begin
      to_d = ToW'(TIMEOUT_CYCLES);
    end else if (to_q != '0) begin
      to_d = to_q - ToW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q <= ToW'(TIMEOUT_CYCLES);
    end else begin
      to_q <= to_d;
    end
  end

  assign timeout = to_run && (to_q == '0) && !rx_valid;
`else
  assign timeout = 1'b0;
`endif

  // Command FSM: next state, datapath updates and FIFO/sequencer controls.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wbuf_d     = wbuf_q;
    bcnt_d     = bcnt_q;
    burst_d    = burst_q;
    err_d      = err_q;
    regs_d     = regs_q;
    strobe_d   = '0;
    fifo_rd_en = 1'b0;
    seq_load   = 1'b0;
    seq_push   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_seen) begin
          addr_d  = rx_data[ADDR_MSB:ADDR_LSB];
          bcnt_d  = '0;
          state_d = rx_data[CMD_WRITE_BIT] ? StWrData : StRdSnap;
        end
      end
      StWrData: begin
        if (rx_valid) begin
          // LSB first: each new byte enters at the top and moves down.
          wbuf_d = (wbuf_q >> 8) | (REG_WIDTH'(rx_data) << (REG_WIDTH - 8));
          if (bcnt_q == BcntW'(REG_BYTES - 1)) begin
            state_d = StWrCommit;
          end else begin
            bcnt_d = bcnt_q + BcntW'(1);
          end
        end
      end
      StWrCommit: begin
        state_d = StIdle;
        if (int'(addr_q) < int'(NUM_REGS)) begin
          for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (int'(addr_q) == i) begin
              regs_d[i*REG_WIDTH +: REG_WIDTH] = wbuf_q;
              strobe_d[i]                      = 1'b1;
            end
          end
          if (addr_q == '0) begin
            err_d = 1'b0;
          end
        end else begin
          err_d = 1'b1;
        end
        // A byte landing on the commit cycle starts the next command.
        if (cmd_seen) begin
          addr_d  = rx_data[ADDR_MSB:ADDR_LSB];
          bcnt_d  = '0;
          state_d = rx_data[CMD_WRITE_BIT] ? StWrData : StRdSnap;
        end
      end
      StRdSnap: begin
        if (rd_hit) begin
          seq_load = 1'b1;
          state_d  = StRdSend;
        end else if (int'(addr_q) == int'(FIFO_ADDR)) begin
          burst_d = '0;
          state_d = StFifoReq;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StRdSend: begin
        if (!seq_pending) begin
          state_d = StIdle;
        end
      end
      StFifoReq: begin
        if (seq_ready) begin
          if (fifo_empty || (burst_q == BurstW'(BURST_MAX))) begin
            state_d = StIdle;
          end else begin
            fifo_rd_en = 1'b1;
            state_d    = StFifoCap;
          end
        end
      end
      StFifoCap: begin
        seq_push = 1'b1;
        burst_d  = burst_q + BurstW'(1);
        state_d  = StFifoReq;
      end
      default: state_d = StIdle;
    endcase

    // Bytes arriving while a read or burst is in progress are dropped.
    if (rx_valid && ((state_q == StRdSnap) || (state_q == StRdSend) ||
                     (state_q == StFifoReq) || (state_q == StFifoCap))) begin
      err_d = 1'b1;
    end

    if (timeout) begin
      state_d    = StIdle;
      err_d      = 1'b1;
      fifo_rd_en = 1'b0;
    end
  end

  // Bridge state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wbuf_q   <= '0;
      bcnt_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      regs_q   <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wbuf_q   <= wbuf_d;
      bcnt_q   <= bcnt_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Self-checking bench for serial_reg_bridge: transaction-level model of the
// register map, status snapshots and FIFO bursts, plus per-cycle monitor.
module tb_serial_reg_bridge;

  localparam int unsigned RW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned SB = 16;
  localparam int unsigned FA = 32;
  localparam int unsigned BM = 4;
  localparam int unsigned TO = 100;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [NR*RW-1:0] reg_q;
  logic [NR-1:0]  reg_wr_strobe;
  logic [NS*RW-1:0] status_in = '0;
  logic           fifo_empty;
  logic [7:0]     fifo_data = 8'h00;
  logic           fifo_rd_en;
  logic           err_flag;

  always #5 clk = ~clk;

  serial_reg_bridge #(
    .REG_WIDTH      (RW),
    .NUM_REGS       (NR),
    .NUM_STATUS     (NS),
    .STATUS_BASE    (SB),
    .FIFO_ADDR      (FA),
    .BURST_MAX      (BM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .reg_q         (reg_q),
    .reg_wr_strobe (reg_wr_strobe),
    .status_in     (status_in),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_rd_en    (fifo_rd_en),
    .err_flag      (err_flag)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  // Transmitter stand-in: busy for a random number of cycles after each start.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= $urandom_range(3, 10);
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Standard (non-FWFT) FIFO stand-in.
  logic [7:0] fifo_mem [256];
  int fifo_wr = 0;
  int fifo_rd = 0;
  assign fifo_empty = (fifo_wr == fifo_rd);
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[fifo_rd % 256];
      fifo_rd   <= fifo_rd + 1;
    end
  end

  // Reference model state.
  logic [31:0] m_regs [NR];
  logic        m_err = 1'b0;
  int          m_fifo_rd = 0;
  logic [7:0]  exp_tx [1024];
  int          exp_wr = 0;
  int          exp_rd = 0;
  int          ws_addr [64];
  logic [31:0] ws_data [64];
  int          ws_wr = 0;
  int          ws_rd = 0;
  logic [7:0]  tx_log [2048];
  int          tx_count = 0;
  logic [NR-1:0] last_strobe = '0;

  function automatic logic [255:0] model_flat();
    logic [255:0] f = '0;
    for (int i = 0; i < int'(NR); i++) f[i*32 +: 32] = m_regs[i];
    return f;
  endfunction

  // Per-cycle monitor: every tx byte and every strobe against expectations.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_start) begin
        check("tx_start_with_busy", tx_busy, 0);
        check("tx_expected", exp_rd < exp_wr, 1);
        if (exp_rd < exp_wr) check("tx_byte", tx_data, exp_tx[exp_rd % 1024]);
        exp_rd <= exp_rd + 1;
        tx_log[tx_count % 2048] <= tx_data;
        tx_count <= tx_count + 1;
      end
      if (reg_wr_strobe != '0) begin
        last_strobe <= reg_wr_strobe;
        check("strobe_expected", ws_rd < ws_wr, 1);
        if (ws_rd < ws_wr) begin
          logic [NR-1:0] oh;
          oh = '0;
          oh[ws_addr[ws_rd % 64]] = 1'b1;
          check("strobe_onehot", reg_wr_strobe, oh);
          check("strobe_reg_value", reg_q[ws_addr[ws_rd % 64]*32 +: 32], ws_data[ws_rd % 64]);
        end
        ws_rd <= ws_rd + 1;
      end
      if (fifo_rd_en) check("fifo_rd_when_empty", fifo_empty, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input int maxgap);
    if (addr < int'(NR)) begin
      ws_addr[ws_wr % 64] = addr;
      ws_data[ws_wr % 64] = data;
      ws_wr++;
      m_regs[addr] = data;
      if (addr == 0) m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    send_byte(8'hC0 | 8'(addr));
    for (int k = 0; k < 4; k++) begin
      idle($urandom_range(0, maxgap));
      send_byte(data[8*k +: 8]);
    end
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_tx[exp_wr % 1024] = b;
    exp_wr++;
  endtask

  task automatic do_read(input int addr);
    logic [31:0] w;
    int n;
    if (addr < int'(NR)) begin
      for (int k = 0; k < 4; k++) push_exp(m_regs[addr][8*k +: 8]);
    end else if (addr >= int'(SB) && addr < int'(SB + NS)) begin
      w = status_in[(addr - int'(SB))*32 +: 32];
      for (int k = 0; k < 4; k++) push_exp(w[8*k +: 8]);
    end else if (addr == int'(FA)) begin
      n = fifo_wr - m_fifo_rd;
      if (n > int'(BM)) n = int'(BM);
      for (int k = 0; k < n; k++) push_exp(fifo_mem[(m_fifo_rd + k) % 256]);
      m_fifo_rd += n;
    end else begin
      m_err = 1'b1;
    end
    send_byte(8'h80 | 8'(addr));
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_mem[fifo_wr % 256] = b;
    fifo_wr++;
  endtask

  task automatic settle(input string name);
    int budget = 4000;
    while (exp_rd != exp_wr && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, "_tx_drained"}, exp_wr - exp_rd, 0);
    idle(25);
    check({name, "_reg_q"}, reg_q, model_flat());
    check({name, "_err_flag"}, err_flag, m_err);
    check({name, "_strobes_seen"}, ws_wr - ws_rd, 0);
    check({name, "_fifo_level"}, fifo_wr - fifo_rd, fifo_wr - m_fifo_rd);
  endtask

  initial begin
    int base;
    int budget;
    int op;
    int a;
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;

    // Reset state.
    idle(3);
    check("rst_reg_q", reg_q, 0);
    check("rst_strobe", reg_wr_strobe, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    check("rst_err_flag", err_flag, 0);
    reset_n = 1'b1;
    idle(2);

    // Multi-byte write of reg 2.
    do_write(2, 32'h12345678, 0);
    settle("wr2");
    check("wr2_literal", reg_q[95:64], 32'h12345678);
    check("wr2_strobe_literal", last_strobe, 8'b0000_0100);

    // Read back reg 2.
    base = tx_count;
    do_read(2);
    settle("rd2");
    check("rd2_count", tx_count - base, 4);
    check("rd2_b0", tx_log[base], 8'h78);
    check("rd2_b1", tx_log[base+1], 8'h56);
    check("rd2_b2", tx_log[base+2], 8'h34);
    check("rd2_b3", tx_log[base+3], 8'h12);

    // Status snapshot is atomic against later status changes.
    status_in[31:0] = 32'hAABBCCDD;
    base = tx_count;
    do_read(16);
    budget = 500;
    while (tx_count == base && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("snap_first_tx_seen", tx_count > base, 1);
    status_in[31:0] = 32'h11111111;
    settle("snap");
    check("snap_b0", tx_log[base], 8'hDD);
    check("snap_b1", tx_log[base+1], 8'hCC);
    check("snap_b2", tx_log[base+2], 8'hBB);
    check("snap_b3", tx_log[base+3], 8'hAA);

    // FIFO bursts limited to BURST_MAX, then empty burst.
    for (int k = 1; k <= 6; k++) fifo_push(8'(k));
    base = tx_count;
    do_read(32);
    settle("burst1");
    check("burst1_count", tx_count - base, 4);
    check("burst1_b0", tx_log[base], 8'h01);
    check("burst1_b3", tx_log[base+3], 8'h04);
    check("burst1_left", fifo_wr - fifo_rd, 2);
    base = tx_count;
    do_read(32);
    settle("burst2");
    check("burst2_count", tx_count - base, 2);
    base = tx_count;
    do_read(32);
    settle("burst_empty");
    check("burst_empty_count", tx_count - base, 0);

    // Unmapped write sets error, write to reg 0 clears it.
    do_write(63, 32'hDEADBEEF, 2);
    settle("wr_unmapped");
    check("wr_unmapped_err_literal", err_flag, 1);
    do_write(0, 32'h00C0FFEE, 2);
    settle("wr0_clear");
    check("wr0_clear_err_literal", err_flag, 0);

    // Next command lands on the commit cycle.
    do_write(3, 32'hA5A5_0303, 0);
    do_write(4, 32'h5A5A_0404, 0);
    settle("b2b_write");

    // Byte during a read is dropped and flags an error; idle junk is ignored.
    do_read(5);
    idle(3);
    send_byte(8'h5A);
    m_err = 1'b1;
    settle("rx_during_read");
    send_byte(8'h12);
    settle("idle_junk");
    do_write(0, $urandom, 1);
    settle("clear_err");

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          a = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 63) : $urandom_range(0, 7);
          do_write(a, $urandom, 2);
        end
        2, 3: begin
          case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 7);
            1: a = $urandom_range(16, 19);
            2: a = 32;
            default: a = $urandom_range(0, 63);
          endcase
          do_read(a);
        end
        4: for (int k = $urandom_range(0, 6); k > 0; k--) fifo_push(8'($urandom));
        default: begin
          status_in = {$urandom, $urandom, $urandom, $urandom};
          send_byte(8'($urandom_range(0, 127)));
        end
      endcase
      settle("random");
    end

`ifdef SERIAL_REG_BRIDGE_TIMEOUT_EN
    // Stalled write times out without touching reg 1.
    send_byte(8'hC1);
    send_byte(8'hAA);
    idle(150);
    m_err = 1'b1;
    settle("timeout");
    check("timeout_err_literal", err_flag, 1);
`endif

    // Reset in the middle of a write.
    send_byte(8'hC1);
    send_byte(8'hAA);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_reg_q", reg_q, 0);
    check("midrst_strobe", reg_wr_strobe, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_start", tx_start, 0);
    check("midrst_fifo_rd_en", fifo_rd_en, 0);
    check("midrst_err_flag", err_flag, 0);
    reset_n = 1'b1;
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    m_err = 1'b0;
    settle("after_reset");
    do_write(6, 32'h0BADF00D, 1);
    settle("post_reset_write");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
